dmem_arbiter: RTL and testbench

Single-port data memory arbiter between the CPU load/store path and a host requester (loader/debug DMA). It sits between the CPU datapath and the `Data_Memory` block-RAM port. Each cycle it grants at most one requester, drives the RAM enable, write-enable, address and data lines, and stalls the CPU while the host owns the port. Read data is routed back to the owner with one-cycle block-RAM latency.

---
 rtl/dmem_arbiter.sv | 77 +++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data memory arbiter between CPU and host, one-cycle read return.
// Define DMEM_ARB_FAIRNESS_EN to let a starved host win contended cycles after STARVE_LIMIT denials.
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  typedef enum logic {ARB, HOST_LOCK} state_e;
  typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_HOST} owner_e;
  state_e state_q, state_d;
  owner_e rd_owner_q, rd_owner_d;
  logic cpu_grant, host_grant, host_wins;
`ifdef DMEM_ARB_FAIRNESS_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;
  assign host_wins = starve_cnt_q == 4'(STARVE_LIMIT);
  assign starve_cnt_d = (host_req & ~host_grant) ? (host_wins ? starve_cnt_q : starve_cnt_q + 4'd1) : 4'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_cnt_q <= '0;
    else starve_cnt_q <= starve_cnt_d;
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign host_wins = 1'b0;
`endif
  // Grants are suppressed combinationally while reset is held.
  always_comb begin
    host_grant = 1'b0;
    cpu_grant = 1'b0;
    state_d = state_q;
    if (!rst) begin
      host_grant = host_req & ((state_q == HOST_LOCK) | ~cpu_req | host_wins);
      cpu_grant = cpu_req & (state_q == ARB) & ~host_grant;
      state_d = (state_q == HOST_LOCK) ? (host_lock ? HOST_LOCK : ARB) : ((host_grant & host_lock) ? HOST_LOCK : ARB);
    end
  end
  assign rd_owner_d = (cpu_grant & ~cpu_we) ? RD_CPU : (host_grant & ~host_we) ? RD_HOST : RD_NONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ARB;
      rd_owner_q <= RD_NONE;
    end else begin
      state_q <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  assign cpu_stall = cpu_req & ~cpu_grant;
  assign host_gnt = host_grant;
  assign mem_en = cpu_grant | host_grant;
  assign mem_we = cpu_grant ? cpu_we : (host_grant & host_we);
  assign mem_addr = cpu_grant ? cpu_addr : host_grant ? host_addr : '0;
  assign mem_din = cpu_grant ? cpu_wdata : host_grant ? host_wdata : '0;
  assign cpu_rvalid = rd_owner_q == RD_CPU;
  assign host_rvalid = rd_owner_q == RD_HOST;
  assign cpu_rdata = mem_dout;
  assign host_rdata = mem_dout;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed bench for dmem_arbiter against a queue-free behavioural model.
module tb_dmem_arbiter;
  localparam int AW = 10, DW = 32, SL = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [AW-1:0] cpu_addr = '0, host_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, host_wdata = '0;
  logic cpu_stall, cpu_rvalid, host_gnt, host_rvalid, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] cpu_rdata, host_rdata, mem_din, mem_dout;
  int n_checks = 0, n_errors = 0;
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] ref_mem [1024];
  bit m_lock = 1'b0;
  int m_wait = 0, m_pend = 0;
  logic [DW-1:0] m_pdata = '0;
  bit c_served, h_served, hdone;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else mem_dout <= ram[mem_addr];
    end

  function automatic bit gh();
    if (rst) return 1'b0;
    if (m_lock) return host_req;
    return host_req && (!cpu_req || (FAIR && m_wait >= SL));
  endfunction

  function automatic bit gc();
    return !rst && !m_lock && cpu_req && !gh();
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_lock <= 1'b0;
      m_wait <= 0;
      m_pend <= 0;
    end else begin
      if (gc() && cpu_we) ref_mem[cpu_addr] <= cpu_wdata;
      if (gh() && host_we) ref_mem[host_addr] <= host_wdata;
      m_pend <= (gc() && !cpu_we) ? 1 : (gh() && !host_we) ? 2 : 0;
      m_pdata <= gc() ? ref_mem[cpu_addr] : ref_mem[host_addr];
      m_wait <= (host_req && !gh()) ? m_wait + 1 : 0;
      m_lock <= m_lock ? host_lock : (gh() && host_lock);
    end

  always @(negedge clk) begin
    chk("cpu_stall", cpu_stall, cpu_req && !gc());
    chk("host_gnt", host_gnt, gh());
    chk("mem_en", mem_en, gc() || gh());
    chk("mem_we", mem_we, gc() ? cpu_we : (gh() && host_we));
    chk("mem_addr", mem_addr, gc() ? cpu_addr : gh() ? host_addr : '0);
    chk("mem_din", mem_din, gc() ? cpu_wdata : gh() ? host_wdata : '0);
    chk("cpu_rvalid", cpu_rvalid, !rst && m_pend == 1);
    chk("host_rvalid", host_rvalid, !rst && m_pend == 2);
    if (!rst && m_pend == 1) chk("cpu_rdata", cpu_rdata, m_pdata);
    if (!rst && m_pend == 2) chk("host_rdata", host_rdata, m_pdata);
  end

  function automatic logic [DW-1:0] w(input int a);
    return 32'hA5A50000 | DW'(a);
  endfunction

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 15) == 0) return 10'h3FF;
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic host_set(input logic r, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = r; host_we = we; host_lock = lk; host_addr = a; host_wdata = d;
  endtask

  initial begin
    cpu_set(1, 1, 0, w(0));
    host_set(1, 1, 0, 10'h3FF, w(32'h3FF));
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_cpu_stall", cpu_stall, 1);
    chk("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cpu_gnt", cpu_stall, 0);
    tick();
    cpu_set(0, 0, 0, 0);
    for (int a = 0; a < 17; a++) begin
      host_set(1, 1, 0, (a == 16) ? 10'h3FF : AW'(a), w((a == 16) ? 32'h3FF : a));
      tick();
    end
    host_set(1, 1, 0, 10'h005, 32'hDEADBEEF);
    tick();
    host_set(0, 0, 0, 0, 0);
    cpu_set(1, 0, 10'h005, 0);
    @(negedge clk);
    chk("rd_stall", cpu_stall, 0);
    tick();
    cpu_set(0, 0, 0, 0);
    @(negedge clk);
    chk("rd_rvalid", cpu_rvalid, 1);
    chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rd_host_rvalid", host_rvalid, 0);
    tick();
    hdone = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cpu_set(1, 0, AW'(c), 0);
      host_set(!hdone, 1, 0, 10'h3FF, 32'h12345678);
      @(negedge clk);
`ifdef DMEM_ARB_FAIRNESS_EN
      chk("fair_host_gnt", host_gnt, c == 4);
      chk("fair_cpu_stall", cpu_stall, c == 4);
`else
      chk("strict_host_gnt", host_gnt, 0);
      chk("strict_cpu_stall", cpu_stall, 0);
`endif
      hdone = hdone | host_gnt;
      tick();
    end
`ifndef DMEM_ARB_FAIRNESS_EN
    cpu_set(0, 0, 0, 0);
    @(negedge clk);
    chk("strict_host_gnt_idle", host_gnt, 1);
    tick();
`endif
    host_set(0, 0, 0, 0, 0);
    cpu_set(1, 0, 10'h3FF, 0);
    tick();
    cpu_set(0, 0, 0, 0);
    @(negedge clk);
    chk("fair_readback", cpu_rdata, 32'h12345678);
    tick();
    host_set(1, 1, 1, 10'h010, 32'h0B000010);
    @(negedge clk);
    chk("lock_gnt0", host_gnt, 1);
    tick();
    for (int k = 1; k < 4; k++) begin
      cpu_set(1, 0, 10'h007, 0);
      host_set(1, 1, k < 3, AW'(16 + k), 32'h0B000010 + DW'(k));
      @(negedge clk);
      chk("lock_gnt", host_gnt, 1);
      chk("lock_stall", cpu_stall, 1);
      tick();
    end
    host_set(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lock_release_cpu", cpu_stall, 0);
    tick();
    cpu_set(1, 0, 10'h001, 0);
    @(negedge clk);
    chk("il_cpu_gnt", cpu_stall, 0);
    tick();
    cpu_set(0, 0, 0, 0);
    host_set(1, 0, 0, 10'h002, 0);
    @(negedge clk);
    chk("il_host_gnt", host_gnt, 1);
    chk("il_cpu_rvalid", cpu_rvalid, 1);
    chk("il_cpu_rdata", cpu_rdata, w(1));
    chk("il_host_rvalid0", host_rvalid, 0);
    tick();
    host_set(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("il_host_rvalid", host_rvalid, 1);
    chk("il_host_rdata", host_rdata, w(2));
    chk("il_cpu_rvalid0", cpu_rvalid, 0);
    tick();
    cpu_set(1, 0, 10'h003, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_set(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_mid_read", cpu_rvalid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_read_after", cpu_rvalid, 0);
    tick();
    c_served = 1'b1;
    h_served = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!cpu_req || c_served)
        cpu_set($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, raddr(), $urandom);
      if (!host_req || h_served)
        host_set($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 0, 0, raddr(), $urandom);
      host_lock = $urandom_range(0, 4) == 0;
      rst = (i % 500) == 250;
      @(negedge clk);
      c_served = !cpu_stall;
      h_served = host_gnt;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
